spu_mpy_pipe: RTL

Parametrised integer multiply pipeline for the SPU single-precision/multiply execution slot.
- Decodes mpy, mpyu, mpyh, mpyi and mpya per 32-bit word lane of the big-endian [0:N-1] operand vectors.
- Carries each result through a configurable-depth pipeline with per-stage valid, stall, flush and destination-hazard visibility.
- Output feeds the register-file writeback stage.

---
 rtl/spu_mpy_pkg.sv | 31 +++
 rtl/spu_mpy_lane.sv | 36 +++
 rtl/spu_mpy_pipe.sv | 92 +++++++++
 3 files changed

// File: rtl/spu_mpy_pkg.sv
// Shared definitions for the SPU integer multiply pipeline: opcodes, op enum, decode helper.
package spu_mpy_pkg;

  localparam logic [10:0] OPC_MPY  = 11'b01111000100;
  localparam logic [10:0] OPC_MPYU = 11'b01111001100;
  localparam logic [10:0] OPC_MPYH = 11'b01111000101;
  localparam logic [7:0]  OPC_MPYI = 8'b01110100;
  localparam logic [3:0]  OPC_MPYA = 4'b1100;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_MPY,
    OP_MPYU,
    OP_MPYH,
    OP_MPYI,
    OP_MPYA
  } mpy_op_t;

  // RR form outranks RI10, which outranks RRR.
  function automatic mpy_op_t decode_op(input logic [10:0] opc11,
                                        input logic [7:0]  opc8,
                                        input logic [3:0]  opc4);
    if (opc11 == OPC_MPY)       return OP_MPY;
    else if (opc11 == OPC_MPYU) return OP_MPYU;
    else if (opc11 == OPC_MPYH) return OP_MPYH;
    else if (opc8 == OPC_MPYI)  return OP_MPYI;
    else if (opc4 == OPC_MPYA)  return OP_MPYA;
    else                        return OP_NONE;
  endfunction

endpackage

// File: rtl/spu_mpy_lane.sv
// Combinational single 32-bit word multiply for one lane; a[15:0] is the low halfword.
module spu_mpy_lane
  import spu_mpy_pkg::*;
(
  input  mpy_op_t     op,
  input  logic [31:0] a,
  input  logic [15:0] b_lo,
  input  logic [31:0] c,
  input  logic [9:0]  imm,
  output logic [31:0] y
);

  logic [31:0] a_lo_s, a_hi_s, b_lo_s, a_lo_u, b_lo_u, imm_s, prod_ss;

  // Sign/zero extend to 32 bits so a plain 32-bit multiply yields the exact low word.
  assign a_lo_s  = {{16{a[15]}}, a[15:0]};
  assign a_hi_s  = {{16{a[31]}}, a[31:16]};
  assign b_lo_s  = {{16{b_lo[15]}}, b_lo};
  assign a_lo_u  = {16'h0000, a[15:0]};
  assign b_lo_u  = {16'h0000, b_lo};
  assign imm_s   = {{22{imm[9]}}, imm};
  assign prod_ss = a_lo_s * b_lo_s;

  always_comb begin
    y = '0;
    case (op)
      OP_MPY:  y = prod_ss;
      OP_MPYU: y = a_lo_u * b_lo_u;
      OP_MPYH: y = (a_hi_s * b_lo_s) << 16;
      OP_MPYI: y = a_lo_s * imm_s;
      OP_MPYA: y = prod_ss + c;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/spu_mpy_pipe.sv
// SPU multiply execution pipe: decode, per-lane compute in stage 0, then a shift register
// of {valid, addr_rt, result} with stall, flush and destination-hazard lookup.
module spu_mpy_pipe
  import spu_mpy_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int STAGES = 7,
  parameter int ADDR_W = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [10:0]           opcode11,
  input  logic [7:0]            opcode8,
  input  logic [3:0]            opcode4,
  input  logic [9:0]            immediate10,
  input  logic [0:LANES*32-1]   ra,
  input  logic [0:LANES*32-1]   rb,
  input  logic [0:LANES*32-1]   rc,
  input  logic [ADDR_W-1:0]     addr_rt,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [ADDR_W-1:0]     query_rt,
  output logic                  busy_rt,
  output logic                  out_valid,
  output logic                  out_wr,
  output logic [ADDR_W-1:0]     out_addr_rt,
  output logic [0:LANES*32-1]   out_result,
  output logic                  illegal_op
);

  localparam int W = LANES * 32;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr_rt;
    logic [0:W-1]      result;
  } stage_t;

  stage_t       pipe [STAGES];
  mpy_op_t      op;
  logic [0:W-1] result_s0;
  logic         accept;

  assign op       = decode_op(opcode11, opcode8, opcode4);
  assign in_ready = !stall;
  assign accept   = in_valid && !stall && !flush && (op != OP_NONE);

  // Word k occupies big-endian bits [32k:32k+31]; its low halfword is [32k+16:32k+31].
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    spu_mpy_lane u_lane (
      .op   (op),
      .a    (ra[32*k +: 32]),
      .b_lo (rb[32*k+16 +: 16]),
      .c    (rc[32*k +: 32]),
      .imm  (immediate10),
      .y    (result_s0[32*k +: 32])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
      illegal_op <= 1'b0;
    end else begin
      illegal_op <= in_valid && !stall && (op == OP_NONE);
      if (flush) begin
        for (int i = 0; i < STAGES; i++) pipe[i].valid <= 1'b0;
      end else if (!stall) begin
        pipe[0].valid <= accept;
        if (accept) begin
          pipe[0].addr_rt <= addr_rt;
          pipe[0].result  <= result_s0;
        end
        for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
      end
    end
  end

  always_comb begin
    busy_rt = 1'b0;
    for (int i = 0; i < STAGES; i++)
      if (pipe[i].valid && (pipe[i].addr_rt == query_rt)) busy_rt = 1'b1;
  end

  assign out_valid   = pipe[STAGES-1].valid;
  assign out_wr      = out_valid && !stall;
  assign out_addr_rt = pipe[STAGES-1].addr_rt;
  assign out_result  = pipe[STAGES-1].result;

endmodule
